// File: rtl/clock_time_ctrl_pkg.sv
// Shared constants, FSM encoding and digit-limit helper for the time-of-day controller.
// Digit index order in the BCD chain: 0 ss units, 1 ss tens, 2 mm units, 3 mm tens, 4 hh units, 5 hh tens.
package clock_time_ctrl_pkg;

  localparam int BCD_BIT_WIDTH = 4;
  localparam int NUM_DIGITS    = 6;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } edit_state_t;

  localparam logic [BCD_BIT_WIDTH-1:0] LIM_UNITS        = 4'd9;
  localparam logic [BCD_BIT_WIDTH-1:0] LIM_TENS         = 4'd5;
  localparam logic [BCD_BIT_WIDTH-1:0] LIM_HR_UNITS_TOP = 4'd3;
  localparam logic [BCD_BIT_WIDTH-1:0] LIM_HR_TENS      = 4'd2;

  // Hour units wrap at 3 only while hour tens sits at its top value (20..23).
  function automatic logic [BCD_BIT_WIDTH-1:0] digit_limit(input int idx,
                                                            input logic [BCD_BIT_WIDTH-1:0] hr_tens);
    logic [BCD_BIT_WIDTH-1:0] lim;
    case (idx)
      1, 3:    lim = LIM_TENS;
      4:       lim = (hr_tens == LIM_HR_TENS) ? LIM_HR_UNITS_TOP : LIM_UNITS;
      5:       lim = LIM_HR_TENS;
      default: lim = LIM_UNITS;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit: counts 0..limit when enabled, synchronous load has priority.
// carry is combinational so a whole rollover resolves within one edge.
module bcd_digit_ctr
  import clock_time_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     load,
  input  logic [BCD_BIT_WIDTH-1:0] load_val,
  input  logic                     en,
  input  logic [BCD_BIT_WIDTH-1:0] limit,
  output logic [BCD_BIT_WIDTH-1:0] q,
  output logic                     carry
);

  logic [BCD_BIT_WIDTH-1:0] q_reg;
  logic [BCD_BIT_WIDTH-1:0] q_next;

  assign carry = en && (q_reg == limit);

  always_comb begin
    q_next = q_reg;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next = (q_reg == limit) ? '0 : q_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/clock_time_ctrl.sv
// 24-hour hh:mm:ss BCD time keeper with a four-state set-mode FSM.
// Set-mode edits reuse the digit enables of one field with the carry into the next field masked.
module clock_time_ctrl
  import clock_time_ctrl_pkg::*;
#(
  parameter logic [7:0] RST_HH = 8'h00,
  parameter logic [7:0] RST_MM = 8'h00,
  parameter logic [7:0] RST_SS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] edit_sel,
  output logic       day_carry
);

  localparam int W = BCD_BIT_WIDTH;
  localparam logic [NUM_DIGITS*W-1:0] RST_ALL = {RST_HH, RST_MM, RST_SS};

  edit_state_t             state_reg;
  edit_state_t             state_next;
  logic [NUM_DIGITS*W-1:0] q_all;
  logic                    run;
  logic                    inc_eff;
  logic                    sec_en;
  logic                    min_en;
  logic                    hr_en;
  logic                    day_carry_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (mode_btn) begin
      case (state_reg)
        RUN:     state_next = SET_HR;
        SET_HR:  state_next = SET_MIN;
        SET_MIN: state_next = SET_SEC;
        SET_SEC: state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  assign run     = (state_reg == RUN);
  assign inc_eff = inc_btn && !mode_btn;

  // In RUN each field is fed by the carry of the field below; in set mode only the edited field moves.
  assign sec_en = run ? tick                  : (state_reg == SET_SEC) && inc_eff;
  assign min_en = run ? gen_digit[1].carry_d : (state_reg == SET_MIN) && inc_eff;
  assign hr_en  = run ? gen_digit[3].carry_d : (state_reg == SET_HR)  && inc_eff;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : gen_digit
    logic en_d;
    logic carry_d;

    if (gi == 0) begin : gen_en
      assign en_d = sec_en;
    end else if (gi == 2) begin : gen_en
      assign en_d = min_en;
    end else if (gi == 4) begin : gen_en
      assign en_d = hr_en;
    end else begin : gen_en
      assign en_d = gen_digit[gi-1].carry_d;
    end

    bcd_digit_ctr u_digit (
      .clk      (clk),
      .load     (!rst),
      .load_val (RST_ALL[gi*W +: W]),
      .en       (en_d),
      .limit    (digit_limit(gi, q_all[5*W +: W])),
      .q        (q_all[gi*W +: W]),
      .carry    (carry_d)
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      day_carry_reg <= 1'b0;
    end else begin
      day_carry_reg <= run && gen_digit[5].carry_d;
    end
  end

  assign ss        = q_all[7:0];
  assign mm        = q_all[15:8];
  assign hh        = q_all[23:16];
  assign edit_sel  = state_reg;
  assign day_carry = day_carry_reg;

endmodule
